// File: rtl/hazard3_mtimer_multi.sv
// Multi-hart RISC-V machine timer: shared 64-bit MTIME, N_HARTS MTIMECMP comparators, APB3 slave.
// Define MTIMER_ATOMIC_READ_EN to latch MTIMEH on each MTIME read for tear-free LO-then-HI reads.
module hazard3_mtimer_multi #(
  parameter int N_HARTS = 2,
  parameter int W_PADDR = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [W_PADDR-1:0] paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [N_HARTS-1:0] dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] timer_irq
);

  localparam int N_WORDS = 4 + 2 * N_HARTS;
  localparam logic [W_PADDR-3:0] A_CTRL  = (W_PADDR-2)'(0);
  localparam logic [W_PADDR-3:0] A_STAT  = (W_PADDR-2)'(1);
  localparam logic [W_PADDR-3:0] A_MTIME = (W_PADDR-2)'(2);
  localparam logic [W_PADDR-3:0] A_MTIMEH = (W_PADDR-2)'(3);

  logic [W_PADDR-3:0] word;
  logic               mapped;
  logic               acc;
  logic               wr;
  logic               rd;
  logic               inc;
  logic               unused_paddr;

  logic                    en_q, en_d;
  logic                    dbgstop_q, dbgstop_d;
  logic [63:0]             mtime_q, mtime_d;
  logic [N_HARTS-1:0][63:0] cmp_q, cmp_d;
  logic [N_HARTS-1:0]      irq_q, irq_d;
  logic [31:0]             mtimeh_rd;

  assign word         = paddr[W_PADDR-1:2];
  assign unused_paddr = ^paddr[1:0];
  assign mapped       = ({1'b0, word} < (W_PADDR-1)'(N_WORDS));
  assign acc          = psel & penable;
  assign wr           = acc & pwrite;
  assign rd           = acc & ~pwrite;
  assign inc          = en_q & tick & ~(dbgstop_q & (|dbg_halt));

`ifdef MTIMER_ATOMIC_READ_EN
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (rd && word == A_MTIME) shadow_d = mtime_q[63:32];
    if (wr && word == A_MTIMEH) shadow_d = pwdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= 32'h0;
    else        shadow_q <= shadow_d;
  end

  assign mtimeh_rd = shadow_q;
`else
  assign mtimeh_rd = mtime_q[63:32];
`endif

  // A write to either MTIME half overrides the increment for that cycle.
  always_comb begin
    en_d      = en_q;
    dbgstop_d = dbgstop_q;
    mtime_d   = mtime_q;
    cmp_d     = cmp_q;
    if (inc) mtime_d = mtime_q + 64'd1;
    if (wr) begin
      if (word == A_CTRL) begin
        en_d      = pwdata[0];
        dbgstop_d = pwdata[1];
      end
      if (word == A_MTIME)  mtime_d = {mtime_q[63:32], pwdata};
      if (word == A_MTIMEH) mtime_d = {pwdata, mtime_q[31:0]};
      for (int i = 0; i < N_HARTS; i++) begin
        if (word == (W_PADDR-2)'(4 + 2 * i)) cmp_d[i][31:0]  = pwdata;
        if (word == (W_PADDR-2)'(5 + 2 * i)) cmp_d[i][63:32] = pwdata;
      end
    end
  end

  always_comb begin
    irq_d = '0;
    for (int i = 0; i < N_HARTS; i++) irq_d[i] = (mtime_q >= cmp_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b1;
      dbgstop_q <= 1'b1;
      mtime_q   <= 64'h0;
      cmp_q     <= {N_HARTS{64'hffff_ffff_ffff_ffff}};
      irq_q     <= '0;
    end else begin
      en_q      <= en_d;
      dbgstop_q <= dbgstop_d;
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    prdata = 32'h0;
    if (psel && mapped) begin
      case (word)
        A_CTRL:   prdata = {30'h0, dbgstop_q, en_q};
        A_STAT:   prdata = 32'(irq_q);
        A_MTIME:  prdata = mtime_q[31:0];
        A_MTIMEH: prdata = mtimeh_rd;
        default: begin
          for (int i = 0; i < N_HARTS; i++) begin
            if (word == (W_PADDR-2)'(4 + 2 * i)) prdata = cmp_q[i][31:0];
            if (word == (W_PADDR-2)'(5 + 2 * i)) prdata = cmp_q[i][63:32];
          end
        end
      endcase
    end
  end

  assign pready    = 1'b1;
  assign pslverr   = acc & ~mapped;
  assign timer_irq = irq_q;

endmodule
